// File: rtl/schoolbook_div.sv
// Restoring shift-subtract divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Optional input registers and a LOAD state are enabled with SCHOOLBOOK_DIV_INREG_EN.
module schoolbook_div #(
  parameter int N = 283
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic [1:0]     dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse on the
  // result edge and q/r/err hold their values between done pulses.
  state_t          state_q, state_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    dq_q, dq_d;
  logic [N-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;

  logic [N:0]      t;
  logic            ge;
  logic [N-1:0]    rem_nx;
  logic            load_go;
  logic [2*N-1:0]  ld_a;
  logic [N-1:0]    ld_b;
  logic            ovf;

`ifdef SCHOOLBOOK_DIV_INREG_EN
  logic [2*N-1:0]  a_in_q, a_in_d;
  assign load_go = (state_q == S_LOAD);
  assign ld_a    = a_in_q;
  assign ld_b    = b_q;
`else
  assign load_go = (state_q == S_IDLE) && start;
  assign ld_a    = a;
  assign ld_b    = b;
`endif

  // The remainder always stays below b, so it is kept in N bits; only the
  // shifted trial value t needs the extra bit, and t - b fits back into N bits.
  assign t      = {rem_q, dq_q[N-1]};
  assign ge     = (t >= {1'b0, b_q});
  assign rem_nx = ge ? (t[N-1:0] - b_q) : t[N-1:0];
  assign ovf    = (ld_a[2*N-1:N] >= ld_b);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef SCHOOLBOOK_DIV_INREG_EN
    a_in_d  = a_in_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d = b;
`ifdef SCHOOLBOOK_DIV_INREG_EN
          a_in_d  = a;
          state_d = S_LOAD;
`endif
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        dq_d  = {dq_q[N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          done_d  = 1'b1;
          err_d   = 1'b0;
          q_d     = {dq_q[N-2:0], ge};
          r_d     = rem_nx;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Overflow (including b == 0) is flagged without ever entering RUN.
    if (load_go) begin
      rem_d = ld_a[2*N-1:N];
      dq_d  = ld_a[N-1:0];
      cnt_d = '0;
      if (ovf) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        q_d     = '1;
        r_d     = '0;
        state_d = S_IDLE;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dq_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef SCHOOLBOOK_DIV_INREG_EN
      a_in_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      q_q     <= q_d;
      r_q     <= r_d;
`ifdef SCHOOLBOOK_DIV_INREG_EN
      a_in_q  <= a_in_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_schoolbook_div.sv
// Directed bench for schoolbook_div (N = 283): latency, results, error path,
// restart immunity, back-to-back operation and asynchronous reset.
module tb_schoolbook_div;
  localparam int N = 283;
  localparam int W = 2 * N;
`ifdef SCHOOLBOOK_DIV_INREG_EN
  localparam int LAT   = N + 1;
  localparam int ELAT  = 1;
  localparam logic EBUSY = 1'b1;
`else
  localparam int LAT   = N;
  localparam int ELAT  = 0;
  localparam logic EBUSY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, err;
  logic [N-1:0] q, r;
  logic [1:0]   dbg_state;

  schoolbook_div #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .q(q), .r(r), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          edges = 0;
  int unsigned cyc = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks; every task starts and ends on a falling edge
  task automatic step();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic launch(input logic [W-1:0] av, input logic [N-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    while (!done && edges < LAT + 20) step();
  endtask

  task automatic finish_op(input string tag, input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic ee, input int elat);
    wait_done();
    check({tag, "_lat"}, W'(edges), W'(elat));
    check({tag, "_done"}, W'(done), W'(1));
    check({tag, "_q"}, W'(q), W'(eq));
    check({tag, "_r"}, W'(r), W'(er));
    check({tag, "_err"}, W'(err), W'(ee));
    step();
    check({tag, "_done_drop"}, W'(done), W'(0));
  endtask

  logic [N-1:0] ones_n;
  logic [W-1:0] opa [3];
  logic [N-1:0] opb [3];
  int unsigned  prev_cyc;

  initial begin
    ones_n = '1;

    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_q", W'(q), W'(0));
    check("rst_r", W'(r), W'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 100 / 7 = 14 r 2
    launch(W'(100), N'(7));
    check("d100_busy", W'(busy), W'(1));
    finish_op("d100", N'(14), N'(2), 1'b0, LAT);

    // largest non-overflowing case
    launch({ones_n - N'(1), ones_n}, ones_n);
    finish_op("max", ones_n, ones_n - N'(1), 1'b0, LAT);

    // divide by zero
    launch(W'(12345), N'(0));
    check("bz_busy", W'(busy), W'(EBUSY));
    finish_op("bz", ones_n, N'(0), 1'b1, ELAT);

    // quotient overflow: high half equals divisor
    launch(W'(5) << N, N'(5));
    check("ovf_busy", W'(busy), W'(EBUSY));
    finish_op("ovf", ones_n, N'(0), 1'b1, ELAT);

    // asynchronous reset during iteration 100
    launch(W'(100), N'(7));
    while (edges < 100) step();
    #1 rst = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_err", W'(err), W'(0));
    check("arst_q", W'(q), W'(0));
    check("arst_r", W'(r), W'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    check("arst_no_done", W'(done), W'(0));
    launch(W'(1000), N'(9));
    finish_op("post_rst", N'(111), N'(1), 1'b0, LAT);

    // start re-pulsed mid-run with different operands is ignored
    launch(W'(100), N'(7));
    while (edges < 50) step();
    a = W'(1000);
    b = N'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_busy", W'(busy), W'(1));
    check("rs_done", W'(done), W'(0));
    check("rs_q_hold", W'(q), W'(111));
    check("rs_r_hold", W'(r), W'(1));
    finish_op("rs", N'(14), N'(2), 1'b0, LAT);

    // start held high: three back-to-back divisions
    opa[0] = W'(100);  opb[0] = N'(7);
    opa[1] = W'(1000); opb[1] = N'(9);
    opa[2] = W'(0);    opb[2] = N'(3);
    exp_q.push_back(W'(14));  exp_q.push_back(W'(2));
    exp_q.push_back(W'(111)); exp_q.push_back(W'(1));
    exp_q.push_back(W'(0));   exp_q.push_back(W'(0));
    prev_cyc = 0;
    a = opa[0];
    b = opb[0];
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      edges = 0;
      @(negedge clk);
      a = '1;
      b = '0;
      wait_done();
      check("bb_lat", W'(edges), W'(LAT));
      if (i > 0) check("bb_gap", W'(cyc - prev_cyc), W'(LAT + 1));
      prev_cyc = cyc;
      check("bb_q", W'(q), exp_q.pop_front());
      check("bb_r", W'(r), exp_q.pop_front());
      check("bb_err", W'(err), W'(0));
      if (i < 2) begin
        a = opa[i + 1];
        b = opb[i + 1];
      end else begin
        start = 1'b0;
      end
    end
    step();
    check("bb_done_drop", W'(done), W'(0));
    check("bb_idle", W'(busy), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
